// File: rtl/sign_flag_pkg.sv
// sign_flag_pkg: shared flag-class enum, default widths and the tuple classifier.
package sign_flag_pkg;
  typedef enum logic [1:0] {CLS_POS, CLS_NEG, CLS_ZERO, CLS_ERR} cls_e;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 16;
  // mag is zero-extended by the caller; w is the real data width (<= 64)
  function automatic cls_e classify(input logic pos, input logic neg, input logic [63:0] mag,
                                    input int unsigned w);
    logic [63:0] h;
    h = 64'd1 << (w - 1);
    return (pos && !neg && mag != '0 && mag <  h) ? CLS_POS  :
           (!pos && neg && mag != '0 && mag <= h) ? CLS_NEG  :
           (!pos && !neg && mag == '0)            ? CLS_ZERO : CLS_ERR;
  endfunction
endpackage

// File: rtl/sign_flag_decoder_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : (inc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/sign_flag_decoder.sv
// sign_flag_decoder: checks (pos, neg, magnitude) tuples, rebuilds two's-complement words
// through one output register stage and keeps saturating per-class statistics.
module sign_flag_decoder
  import sign_flag_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             positive_flag,
  input  logic             negative_flag,
  input  logic [WIDTH-1:0] magnitude,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic             err_sticky,
  input  logic             clr,
  output logic [CNT_W-1:0] pos_cnt,
  output logic [CNT_W-1:0] neg_cnt,
  output logic [CNT_W-1:0] zero_cnt,
  output logic [CNT_W-1:0] err_cnt
);
  logic             valid_q, valid_d, err_q, err_d, sticky_q, sticky_d, accept;
  logic [WIDTH-1:0] data_q, data_d, decoded;
  cls_e             cls;
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign cls      = classify(positive_flag, negative_flag, 64'(magnitude), WIDTH);
  assign decoded  = (cls == CLS_POS) ? magnitude : (cls == CLS_NEG) ? ~magnitude + 1'b1 : '0;
  always_comb begin
    valid_d  = accept ? 1'b1 : out_ready ? 1'b0 : valid_q;
    data_d   = accept ? decoded : data_q;
    err_d    = accept ? (cls == CLS_ERR) : err_q;
    sticky_d = clr ? 1'b0 : (accept && cls == CLS_ERR) ? 1'b1 : sticky_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      data_q   <= data_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
    end
  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign out_err    = err_q;
  assign err_sticky = sticky_q;
  sat_counter #(.CNT_W(CNT_W)) u_pos  (.clk(clk), .rst_n(rst_n), .inc(accept && cls == CLS_POS),
                                       .clr(clr), .cnt(pos_cnt));
  sat_counter #(.CNT_W(CNT_W)) u_neg  (.clk(clk), .rst_n(rst_n), .inc(accept && cls == CLS_NEG),
                                       .clr(clr), .cnt(neg_cnt));
  sat_counter #(.CNT_W(CNT_W)) u_zero (.clk(clk), .rst_n(rst_n), .inc(accept && cls == CLS_ZERO),
                                       .clr(clr), .cnt(zero_cnt));
  sat_counter #(.CNT_W(CNT_W)) u_err  (.clk(clk), .rst_n(rst_n), .inc(accept && cls == CLS_ERR),
                                       .clr(clr), .cnt(err_cnt));
endmodule

// File: tb/tb_sign_flag_decoder.sv
// tb_sign_flag_decoder: scenario tasks plus a randomized run against an arithmetic reference model.
module tb_sign_flag_decoder;
  localparam int W = 16, CW = 4, SAT = 15, H = 32768;
  logic clk = 0, rst_n = 0, in_valid = 0, positive_flag = 0, negative_flag = 0, out_ready = 0, clr = 0;
  logic [W-1:0] magnitude = '0;
  logic in_ready, out_valid, out_err, err_sticky;
  logic [W-1:0] out_data;
  logic [CW-1:0] pos_cnt, neg_cnt, zero_cnt, err_cnt;
  int errors = 0, checks = 0;
  bit m_valid, m_err, m_sticky, pre_rdy;
  logic [W-1:0] m_data;
  int m_cnt[4];

  sign_flag_decoder #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .positive_flag(positive_flag), .negative_flag(negative_flag), .magnitude(magnitude),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .err_sticky(err_sticky), .clr(clr), .pos_cnt(pos_cnt), .neg_cnt(neg_cnt),
    .zero_cnt(zero_cnt), .err_cnt(err_cnt));

  always #5 clk = ~clk;

  // 0=positive 1=negative 2=zero 3=illegal, straight from the decode table
  function automatic int ref_cls(bit p, bit n, int m);
    if (p && !n && m > 0 && m < H) return 0;
    if (!p && n && m > 0 && m <= H) return 1;
    if (!p && !n && m == 0) return 2;
    return 3;
  endfunction

  function automatic logic [W-1:0] ref_val(bit p, bit n, int m);
    int c = ref_cls(p, n, m);
    return (c == 0) ? W'(m) : (c == 1) ? W'((65536 - m) % 65536) : '0;
  endfunction

  task automatic reset_model();
    m_valid = 0; m_err = 0; m_sticky = 0; m_data = '0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  // Drive one cycle from posedge+1, record pre-edge in_ready, advance the model, return at posedge+1.
  task automatic step(input bit v, input bit p, input bit n, input int m, input bit ordy, input bit c);
    bit acc;
    int k;
    in_valid = v; positive_flag = p; negative_flag = n; magnitude = W'(m); out_ready = ordy; clr = c;
    #1 pre_rdy = in_ready;
    @(posedge clk);
    acc = v && (!m_valid || ordy);
    k = ref_cls(p, n, m);
    if (acc) begin
      m_valid = 1; m_data = ref_val(p, n, m); m_err = (k == 3);
    end else if (ordy) m_valid = 0;
    if (c) begin
      m_sticky = 0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end else if (acc) begin
      if (m_cnt[k] < SAT) m_cnt[k]++;
      if (k == 3) m_sticky = 1;
    end
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0 || err_sticky !== 1'b0) begin errors++;
      $display("FAIL reset_out valid=%b sticky=%b want 0 0", out_valid, err_sticky); end
    checks++; if ({pos_cnt, neg_cnt, zero_cnt, err_cnt} !== '0) begin errors++;
      $display("FAIL reset_cnt got %h want 0", {pos_cnt, neg_cnt, zero_cnt, err_cnt}); end
    reset_model();
    @(negedge clk) rst_n = 1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_legal();
    int m[3] = '{5, 5, 0};
    bit p[3] = '{1, 0, 0};
    bit n[3] = '{0, 1, 0};
    logic [W-1:0] exp[3] = '{16'h0005, 16'hFFFB, 16'h0000};
    for (int i = 0; i < 3; i++) begin
      step(1, p[i], n[i], m[i], 1, 0);
      checks++; if (out_valid !== 1'b1 || out_data !== exp[i] || out_err !== 1'b0) begin errors++;
        $display("FAIL legal_%0d got v=%b d=%h e=%b want 1 %h 0", i, out_valid, out_data, out_err, exp[i]); end
    end
    idle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL legal_drain got %b want 0", out_valid); end
    checks++; if (pos_cnt !== 1 || neg_cnt !== 1 || zero_cnt !== 1 || err_cnt !== 0) begin errors++;
      $display("FAIL legal_cnt got %0d/%0d/%0d/%0d want 1/1/1/0", pos_cnt, neg_cnt, zero_cnt, err_cnt); end
  endtask

  task automatic test_boundary();
    step(1, 0, 1, 16'h8000, 1, 0);
    checks++; if (out_data !== 16'h8000 || out_err !== 1'b0) begin errors++;
      $display("FAIL bnd_neg_h got %h e=%b want 8000 0", out_data, out_err); end
    step(1, 1, 0, 16'h7FFF, 1, 0);
    checks++; if (out_data !== 16'h7FFF || out_err !== 1'b0) begin errors++;
      $display("FAIL bnd_pos_max got %h e=%b want 7fff 0", out_data, out_err); end
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL bnd_sticky_pre got %b want 0", err_sticky); end
    step(1, 1, 0, 16'h8000, 1, 0);
    checks++; if (out_data !== 16'h0000 || out_err !== 1'b1 || err_sticky !== 1'b1) begin errors++;
      $display("FAIL bnd_pos_h got %h e=%b s=%b want 0000 1 1", out_data, out_err, err_sticky); end
    idle();
  endtask

  task automatic test_illegal();
    step(0, 0, 0, 0, 1, 1);
    step(1, 1, 1, 3, 1, 0);
    checks++; if (out_data !== 16'h0000 || out_err !== 1'b1) begin errors++;
      $display("FAIL ill_both got %h e=%b want 0000 1", out_data, out_err); end
    step(1, 0, 0, 1, 1, 0);
    checks++; if (out_data !== 16'h0000 || out_err !== 1'b1) begin errors++;
      $display("FAIL ill_noflag got %h e=%b want 0000 1", out_data, out_err); end
    idle();
    checks++; if (err_cnt !== 2 || pos_cnt !== 0 || neg_cnt !== 0 || zero_cnt !== 0 || err_sticky !== 1'b1) begin
      errors++; $display("FAIL ill_cnt got err=%0d p/n/z=%0d/%0d/%0d s=%b want 2 0/0/0 1",
                         err_cnt, pos_cnt, neg_cnt, zero_cnt, err_sticky); end
  endtask

  task automatic test_back_to_back();
    step(1, 1, 0, 16'h0011, 0, 0);
    checks++; if (pre_rdy !== 1'b1 || out_valid !== 1'b1 || out_data !== 16'h0011) begin errors++;
      $display("FAIL bp_first r=%b v=%b d=%h want 1 1 0011", pre_rdy, out_valid, out_data); end
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 1, 16'h0022, 0, 0);
      checks++; if (pre_rdy !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'h0011) begin errors++;
        $display("FAIL bp_hold_%0d r=%b v=%b d=%h want 0 1 0011", i, pre_rdy, out_valid, out_data); end
    end
    step(1, 0, 1, 16'h0022, 1, 0);
    checks++; if (pre_rdy !== 1'b1 || out_valid !== 1'b1 || out_data !== 16'hFFDE) begin errors++;
      $display("FAIL bp_second r=%b v=%b d=%h want 1 1 ffde", pre_rdy, out_valid, out_data); end
    idle();
    checks++; if (out_valid !== 1'b0 || pos_cnt !== 1 || neg_cnt !== 1) begin errors++;
      $display("FAIL bp_drain v=%b p=%0d n=%0d want 0 1 1", out_valid, pos_cnt, neg_cnt); end
  endtask

  task automatic test_clr();
    step(1, 0, 0, 9, 1, 0);
    checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL clr_pre got %b want 1", err_sticky); end
    step(1, 1, 1, 5, 1, 1);
    checks++; if (out_err !== 1'b1 || out_data !== 16'h0000 || out_valid !== 1'b1) begin errors++;
      $display("FAIL clr_word v=%b d=%h e=%b want 1 0000 1", out_valid, out_data, out_err); end
    checks++; if ({pos_cnt, neg_cnt, zero_cnt, err_cnt} !== '0 || err_sticky !== 1'b0) begin errors++;
      $display("FAIL clr_stats cnt=%h s=%b want 0 0", {pos_cnt, neg_cnt, zero_cnt, err_cnt}, err_sticky); end
    idle();
  endtask

  task automatic test_random();
    int mags[8] = '{0, 1, 2, 16'h7FFE, 16'h7FFF, 16'h8000, 16'h8001, 16'hFFFF};
    int m;
    for (int i = 0; i < 400; i++) begin
      m = ($urandom_range(0, 1) == 0) ? mags[$urandom_range(0, 7)] : int'($urandom_range(0, 65535));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, m,
           $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
      checks++;
      if (out_valid !== m_valid || (m_valid && (out_data !== m_data || out_err !== m_err)) ||
          err_sticky !== m_sticky || pos_cnt !== CW'(m_cnt[0]) || neg_cnt !== CW'(m_cnt[1]) ||
          zero_cnt !== CW'(m_cnt[2]) || err_cnt !== CW'(m_cnt[3])) begin
        errors++;
        $display("FAIL rand_%0d got v=%b d=%h e=%b s=%b c=%0d/%0d/%0d/%0d want %b %h %b %b %0d/%0d/%0d/%0d",
                 i, out_valid, out_data, out_err, err_sticky, pos_cnt, neg_cnt, zero_cnt, err_cnt,
                 m_valid, m_data, m_err, m_sticky, m_cnt[0], m_cnt[1], m_cnt[2], m_cnt[3]);
      end
    end
    idle();
  endtask

  task automatic test_saturation();
    step(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 20; i++) step(1, 1, 0, i + 1, 1, 0);
    checks++; if (pos_cnt !== 4'd15 || neg_cnt !== 0 || zero_cnt !== 0 || err_cnt !== 0) begin errors++;
      $display("FAIL sat got %0d/%0d/%0d/%0d want 15/0/0/0", pos_cnt, neg_cnt, zero_cnt, err_cnt); end
  endtask

  task automatic test_async_reset();
    step(1, 0, 1, 7, 0, 0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre got %b want 1", out_valid); end
    #2 rst_n = 0;
    #1;
    checks++; if (out_valid !== 1'b0 || {pos_cnt, neg_cnt, zero_cnt, err_cnt} !== '0 || err_sticky !== 1'b0) begin
      errors++; $display("FAIL arst got v=%b cnt=%h s=%b want 0 0 0", out_valid,
                         {pos_cnt, neg_cnt, zero_cnt, err_cnt}, err_sticky); end
    reset_model();
    in_valid = 0;
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
      $display("FAIL arst_post v=%b r=%b want 0 1", out_valid, in_ready); end
  endtask

  initial begin
    test_reset();
    test_legal();
    test_boundary();
    test_illegal();
    test_back_to_back();
    test_clr();
    test_random();
    test_saturation();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
